pipe_core_param: RTL and testbench

Parametrised three-stage (ID/EX/WB) integer pipeline core, fed through a registered instruction-input stage. It is the next generation of the team's 8-bit forwarding core, with configurable data width and register count, a four-operation ALU and a valid/ready instruction handshake. It adds an explicit writeback observation port and a debug register read port. It sits between an instruction source (fetch unit or testbench streamer) and the writeback/trace logic.

---
 rtl/pipe_core_param_if.sv | 29 ++
 rtl/pipe_core_param.sv | 136 +++++++++++++
 tb/tb_pipe_core_param.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_core_param_if.sv
// pipe_core_param_if: instruction valid/ready handshake, writeback observation
// and debug read bundle for pipe_core_param (master = source/tb, slave = core).
interface pipe_core_param_if #(
  parameter int XLEN = 8,
  parameter int NREG = 8
);
  localparam int RW = $clog2(NREG);
  localparam int IW = 2 + 2 * RW;

  logic            in_valid;
  logic [IW-1:0]   in_instr;
  logic            in_ready;
  logic            wb_valid;
  logic [RW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_zero;
  logic [RW-1:0]   dbg_addr;
  logic [XLEN-1:0] dbg_data;

  modport master (
    output in_valid, in_instr, dbg_addr,
    input  in_ready, wb_valid, wb_rd, wb_data, wb_zero, dbg_data
  );

  modport slave (
    input  in_valid, in_instr, dbg_addr,
    output in_ready, wb_valid, wb_rd, wb_data, wb_zero, dbg_data
  );
endinterface

// File: rtl/pipe_core_param.sv
// pipe_core_param: IF/ID -> ID -> EX -> WB integer pipeline, ADD/SUB/SLL/AND.
// Ports: clk, rst (async high), bus (slave). PIPE_FWD_EN: EX/WB->EX forwarding.
module pipe_core_param #(
  parameter int XLEN = 8,
  parameter int NREG = 8
) (
  input  logic clk,
  input  logic rst,
  pipe_core_param_if.slave bus
);
  localparam int RW = $clog2(NREG);
  localparam int IW = 2 + 2 * RW;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_SLL = 2'b10,
    OP_AND = 2'b11
  } op_e;

  logic [XLEN-1:0] rf [NREG];

  logic            fd_v;
  logic [IW-1:0]   fd_instr;

  logic            de_v;
  op_e             de_op;
  logic [RW-1:0]   de_rd;
  logic [RW-1:0]   de_rs2;
  logic [XLEN-1:0] de_a;
  logic [XLEN-1:0] de_b;

  logic            ew_v;
  logic [RW-1:0]   ew_rd;
  logic [XLEN-1:0] ew_data;
  logic            ew_zero;

  op_e             id_op;
  logic [RW-1:0]   id_rd;
  logic [RW-1:0]   id_rs2;
  logic            id_use2;
  logic [XLEN-1:0] id_a;
  logic [XLEN-1:0] id_b;
  logic            stall;

  logic [XLEN-1:0] ex_a;
  logic [XLEN-1:0] ex_b;
  logic [XLEN-1:0] ex_res;

  assign id_op   = op_e'(fd_instr[IW-1:IW-2]);
  assign id_rd   = fd_instr[2*RW-1:RW];
  assign id_rs2  = fd_instr[RW-1:0];
  assign id_use2 = (id_op != OP_SLL);

  // WB writes at the end of this cycle; hand its value straight to ID.
  assign id_a = (ew_v && ew_rd == id_rd)  ? ew_data : rf[id_rd];
  assign id_b = (ew_v && ew_rd == id_rs2) ? ew_data : rf[id_rs2];

`ifdef PIPE_FWD_EN
  logic de_use2;

  assign stall = 1'b0;
  assign ex_a  = (ew_v && ew_rd == de_rd) ? ew_data : de_a;
  assign ex_b  = (de_use2 && ew_v && ew_rd == de_rs2)
               ? ew_data : de_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) de_use2 <= 1'b0;
    else     de_use2 <= id_use2;
  end
`else
  // Producer one ahead: wait a cycle so the regfile bypass covers it.
  assign stall = fd_v && de_v &&
                 (id_rd == de_rd || (id_use2 && id_rs2 == de_rd));
  assign ex_a  = de_a;
  assign ex_b  = de_b;
`endif

  assign bus.in_ready = !rst && !stall;

  always_comb begin
    ex_res = '0;
    unique case (de_op)
      OP_ADD: ex_res = ex_a + ex_b;
      OP_SUB: ex_res = ex_a - ex_b;
      OP_SLL: ex_res = ex_a << de_rs2;
      OP_AND: ex_res = ex_a & ex_b;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fd_v     <= 1'b0;
      fd_instr <= '0;
      de_v     <= 1'b0;
      de_op    <= OP_ADD;
      de_rd    <= '0;
      de_rs2   <= '0;
      de_a     <= '0;
      de_b     <= '0;
      ew_v     <= 1'b0;
      ew_rd    <= '0;
      ew_data  <= '0;
      ew_zero  <= 1'b0;
    end else begin
      if (!stall) begin
        fd_v     <= bus.in_valid;
        fd_instr <= bus.in_instr;
      end
      de_v    <= fd_v && !stall;
      de_op   <= id_op;
      de_rd   <= id_rd;
      de_rs2  <= id_rs2;
      de_a    <= id_a;
      de_b    <= id_b;
      ew_v    <= de_v;
      ew_rd   <= de_rd;
      ew_data <= ex_res;
      ew_zero <= (ex_res == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= XLEN'(i);
    end else if (ew_v) begin
      rf[ew_rd] <= ew_data;
    end
  end

  assign bus.wb_valid = ew_v;
  assign bus.wb_rd    = ew_rd;
  assign bus.wb_data  = ew_data;
  assign bus.wb_zero  = ew_zero;
  assign bus.dbg_data = rf[bus.dbg_addr];
endmodule

// File: tb/tb_pipe_core_param.sv
// tb_pipe_core_param: directed tests for pipe_core_param at XLEN=8, NREG=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pipe_core_param;
  localparam int XLEN = 8;
  localparam int NREG = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_core_param_if #(.XLEN(XLEN), .NREG(NREG)) bus ();

  pipe_core_param #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic reset_dut();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.dbg_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.dbg_addr = 3'd3;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_ready got=%b exp=0", bus.in_ready);
    end
    checks++;
    if ({bus.wb_valid, bus.wb_zero} !== 2'b00) begin
      failures++;
      $display("FAIL rst_wb_flags got=%b%b exp=00",
               bus.wb_valid, bus.wb_zero);
    end
    checks++;
    if ({bus.wb_rd, bus.wb_data} !== 11'd0) begin
      failures++;
      $display("FAIL rst_wb_bus got=%0d/%0h exp=0/0",
               bus.wb_rd, bus.wb_data);
    end
    checks++;
    if (bus.dbg_data !== 8'd3) begin
      failures++;
      $display("FAIL rst_r3 got=%0h exp=3", bus.dbg_data);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rel_ready got=%b exp=1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_instr = 8'h0A;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.wb_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_rst_wbv got=%b exp=1", bus.wb_valid);
    end
    #1 rst = 1'b1;
    bus.dbg_addr = 3'd1;
    #1;
    checks++;
    if (bus.wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_wbv got=%b exp=0", bus.wb_valid);
    end
    checks++;
    if (bus.dbg_data !== 8'd1) begin
      failures++;
      $display("FAIL mid_rst_r1 got=%0h exp=1", bus.dbg_data);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rel2_ready got=%b exp=1", bus.in_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_rst_wbv got=%b exp=0", bus.wb_valid);
    end
    checks++;
    if (bus.dbg_data !== 8'd1) begin
      failures++;
      $display("FAIL post_rst_r1 got=%0h exp=1", bus.dbg_data);
    end
    bus.dbg_addr = 3'd3;
    #1;
    checks++;
    if (bus.dbg_data !== 8'd3) begin
      failures++;
      $display("FAIL post_rst_r3 got=%0h exp=3", bus.dbg_data);
    end
  endtask

  task automatic test_single();
    reset_dut();
    bus.dbg_addr = 3'd1;
    bus.in_valid = 1'b1;
    bus.in_instr = 8'h0A;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (bus.wb_valid !== 1'b0) begin
        failures++;
        $display("FAIL single_early%0d got=%b exp=0", c, bus.wb_valid);
      end
      @(negedge clk);
    end
    checks++;
    if ({bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_zero}
        !== {1'b1, 3'd1, 8'd3, 1'b0}) begin
      failures++;
      $display("FAIL single_wb got=%b/%0d/%0h/%b exp=1/1/3/0",
               bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_zero);
    end
    checks++;
    if (bus.dbg_data !== 8'd1) begin
      failures++;
      $display("FAIL single_r1_pre got=%0h exp=1", bus.dbg_data);
    end
    @(negedge clk);
    checks++;
    if (bus.dbg_data !== 8'd3) begin
      failures++;
      $display("FAIL single_r1_post got=%0h exp=3", bus.dbg_data);
    end
    checks++;
    if (bus.wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_after got=%b exp=0", bus.wb_valid);
    end
  endtask

  task automatic test_dist1();
    logic exp_rdy;
`ifdef PIPE_FWD_EN
    exp_rdy = 1'b1;
`else
    exp_rdy = 1'b0;
`endif
    reset_dut();
    bus.in_valid = 1'b1;
    bus.in_instr = 8'h0A;
    @(negedge clk);
    bus.in_instr = 8'h59;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== exp_rdy) begin
      failures++;
      $display("FAIL d1_ready got=%b exp=%b", bus.in_ready, exp_rdy);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.wb_valid, bus.wb_rd, bus.wb_data}
        !== {1'b1, 3'd1, 8'd3}) begin
      failures++;
      $display("FAIL d1_wb0 got=%b/%0d/%0h exp=1/1/3",
               bus.wb_valid, bus.wb_rd, bus.wb_data);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL d1_ready2 got=%b exp=1", bus.in_ready);
    end
    @(negedge clk);
`ifndef PIPE_FWD_EN
    checks++;
    if (bus.wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL d1_bubble got=%b exp=0", bus.wb_valid);
    end
    @(negedge clk);
`endif
    checks++;
    if ({bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_zero}
        !== {1'b1, 3'd3, 8'd0, 1'b1}) begin
      failures++;
      $display("FAIL d1_wb1 got=%b/%0d/%0h/%b exp=1/3/0/1",
               bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_zero);
    end
    bus.dbg_addr = 3'd3;
    @(negedge clk);
    checks++;
    if (bus.dbg_data !== 8'd0) begin
      failures++;
      $display("FAIL d1_r3 got=%0h exp=0", bus.dbg_data);
    end
  endtask

  task automatic test_dist2();
    logic [7:0] prog [3];
    logic [2:0] erd [3];
    logic [7:0] edat [3];
    prog = '{8'h0A, 8'hEE, 8'h21};
    erd  = '{3'd1, 3'd5, 3'd4};
    edat = '{8'd3, 8'd4, 8'd7};
    reset_dut();
    bus.in_valid = 1'b1;
    bus.in_instr = prog[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.in_valid = (c + 1 < 3);
      bus.in_instr = (c + 1 < 3) ? prog[c+1] : 8'h00;
      if (c < 2) begin
        checks++;
        if (bus.in_ready !== 1'b1) begin
          failures++;
          $display("FAIL d2_ready%0d got=%b exp=1", c, bus.in_ready);
        end
      end else begin
        checks++;
        if ({bus.wb_valid, bus.wb_rd, bus.wb_data}
            !== {1'b1, erd[c-2], edat[c-2]}) begin
          failures++;
          $display("FAIL d2_wb%0d got=%b/%0d/%0h exp=1/%0d/%0h",
                   c - 2, bus.wb_valid, bus.wb_rd, bus.wb_data,
                   erd[c-2], edat[c-2]);
        end
      end
    end
  endtask

  task automatic test_shift_wrap();
    reset_dut();
    bus.in_valid = 1'b1;
    bus.in_instr = 8'hBB;
    @(negedge clk);
    bus.in_instr = 8'h41;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_zero}
        !== {1'b1, 3'd7, 8'h38, 1'b0}) begin
      failures++;
      $display("FAIL sll_wb got=%b/%0d/%0h/%b exp=1/7/38/0",
               bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_zero);
    end
    @(negedge clk);
    checks++;
    if ({bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_zero}
        !== {1'b1, 3'd0, 8'hFF, 1'b0}) begin
      failures++;
      $display("FAIL wrap_wb got=%b/%0d/%0h/%b exp=1/0/ff/0",
               bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_zero);
    end
  endtask

  task automatic test_backpressure();
    logic       v [6];
    logic [7:0] prog [6];
    logic [2:0] erd [6];
    logic [7:0] edat [6];
    logic [2:0] da [5];
    logic [7:0] dv [5];
    v    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    prog = '{8'h0A, 8'h00, 8'hBB, 8'h00, 8'h41, 8'h00};
    erd  = '{3'd1, 3'd0, 3'd7, 3'd0, 3'd0, 3'd0};
    edat = '{8'd3, 8'd0, 8'h38, 8'd0, 8'hFD, 8'd0};
    da   = '{3'd1, 3'd7, 3'd0, 3'd2, 3'd6};
    dv   = '{8'd3, 8'h38, 8'hFD, 8'd2, 8'd6};
    reset_dut();
    bus.in_valid = v[0];
    bus.in_instr = prog[0];
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.in_valid = (c + 1 < 6) ? v[c+1] : 1'b0;
      bus.in_instr = (c + 1 < 6) ? prog[c+1] : 8'h00;
      if (c >= 2) begin
        checks++;
        if (bus.wb_valid !== v[c-2]) begin
          failures++;
          $display("FAIL bp_wbv%0d got=%b exp=%b",
                   c - 2, bus.wb_valid, v[c-2]);
        end
        if (v[c-2]) begin
          checks++;
          if ({bus.wb_rd, bus.wb_data} !== {erd[c-2], edat[c-2]}) begin
            failures++;
            $display("FAIL bp_wb%0d got=%0d/%0h exp=%0d/%0h",
                     c - 2, bus.wb_rd, bus.wb_data,
                     erd[c-2], edat[c-2]);
          end
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      bus.dbg_addr = da[i];
      #1;
      checks++;
      if (bus.dbg_data !== dv[i]) begin
        failures++;
        $display("FAIL bp_r%0d got=%0h exp=%0h",
                 da[i], bus.dbg_data, dv[i]);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.dbg_addr = '0;
    test_reset();
    test_single();
    test_dist1();
    test_dist2();
    test_shift_wrap();
    test_backpressure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
